// File: rtl/dac_output_pkg.sv
// Shared constants, envelope state encoding and the DAC saturation helper
// for the DAC output stage.
package dac_output_pkg;

    localparam int AXIS_TDATA_WIDTH = 16;
    localparam int DAC_WIDTH        = 14;
    localparam int P_WIDTH          = 18;   // gain / envelope product width
    localparam int SUM_WIDTH        = 19;   // product plus offset

    localparam logic [15:0] ENV_FULL = 16'h8000;

    localparam int DAC_MIN = -(2 ** (DAC_WIDTH - 1));
    localparam int DAC_MAX = (2 ** (DAC_WIDTH - 1)) - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_t;

    typedef struct packed {
        logic                        clipped;
        logic signed [DAC_WIDTH-1:0] code;
    } sat_result_t;

    function automatic sat_result_t saturate(input logic signed [SUM_WIDTH-1:0] s);
        sat_result_t r;
        if (int'(s) > DAC_MAX) begin
            r.clipped = 1'b1;
            r.code    = DAC_WIDTH'(DAC_MAX);
        end else if (int'(s) < DAC_MIN) begin
            r.clipped = 1'b1;
            r.code    = DAC_WIDTH'(DAC_MIN);
        end else begin
            r.clipped = 1'b0;
            r.code    = DAC_WIDTH'(s);
        end
        return r;
    endfunction

endpackage

// File: rtl/dac_output_stage_envelope.sv
// Soft on/off envelope: a four-state FSM and the 0..ENV_FULL envelope
// register, stepping once per accepted sample.
module dac_envelope_ramp
    import dac_output_pkg::*;
(
    input  logic        clk,
    input  logic        aresetn,
    input  logic        advance,
    input  logic        enable,
    input  logic [15:0] step,
    output logic [15:0] env,
    output ramp_state_t state
);

    logic [15:0] env_reg;
    logic [15:0] env_next;
    ramp_state_t state_reg;
    ramp_state_t state_next;

    logic [16:0] up_sum;
    logic [15:0] env_up;
    logic [15:0] env_dn;

    // A zero step means "switch instantly", so both directions saturate in one sample.
    always_comb begin
        up_sum = {1'b0, env_reg} + {1'b0, step};
        env_up = (step == 16'd0 || up_sum >= {1'b0, ENV_FULL}) ? ENV_FULL : up_sum[15:0];
        env_dn = (step == 16'd0 || step >= env_reg) ? 16'd0 : env_reg - step;
    end

    always_comb begin
        env_next   = env_reg;
        state_next = state_reg;
        if (advance) begin
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        env_next   = env_up;
                        state_next = (env_up == ENV_FULL) ? RUN : RAMP_UP;
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    // A direction change continues from the current envelope value.
                    if (enable) begin
                        env_next   = env_up;
                        state_next = (env_up == ENV_FULL) ? RUN : RAMP_UP;
                    end else begin
                        env_next   = env_dn;
                        state_next = (env_dn == 16'd0) ? IDLE : RAMP_DOWN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        env_next   = env_dn;
                        state_next = (env_dn == 16'd0) ? IDLE : RAMP_DOWN;
                    end
                end
                default: begin
                    env_next   = 16'd0;
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            env_reg   <= 16'd0;
            state_reg <= IDLE;
        end else begin
            env_reg   <= env_next;
            state_reg <= state_next;
        end
    end

    assign env   = env_reg;
    assign state = state_reg;

endmodule

// File: rtl/dac_output_stage.sv
// DAC output stage: gain, envelope and offset applied to each AXI-Stream
// sample, then clamped to the DAC code range and sign-extended.
module dac_output_stage
    import dac_output_pkg::*;
(
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic                        s_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                        s_axis_tready,
    input  logic [15:0]                 cfg_amplitude,
    input  logic [DAC_WIDTH-1:0]        cfg_offset,
    input  logic [15:0]                 cfg_ramp_step,
    input  logic                        enable,
    output logic                        m_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [1:0]                  ramp_state,
    output logic                        saturated
);

    localparam int NUM_VALID = 5;

    logic        tready_reg;
    logic        accept;
    logic [15:0] env;
    ramp_state_t state;

    logic valid_reg [0:NUM_VALID-1];

    logic signed [AXIS_TDATA_WIDTH-1:0] s1_data_reg;
    logic        [15:0]                 s1_env_reg;
    logic signed [P_WIDTH-1:0]          p1_reg;
    logic        [15:0]                 s2_env_reg;
    logic signed [P_WIDTH-1:0]          p2_reg;
    logic signed [SUM_WIDTH-1:0]        sum_reg;
    logic signed [DAC_WIDTH-1:0]        code_reg;
    logic                               sat_reg;

    logic signed [32:0]          gain_prod;
    logic signed [34:0]          env_prod;
    logic signed [P_WIDTH-1:0]   p1_next;
    logic signed [P_WIDTH-1:0]   p2_next;
    logic signed [SUM_WIDTH-1:0] sum_next;
    sat_result_t                 sat_res;

    assign accept = s_axis_tvalid & tready_reg;

    dac_envelope_ramp u_envelope (
        .clk     (clk),
        .aresetn (aresetn),
        .advance (accept),
        .enable  (enable),
        .step    (cfg_ramp_step),
        .env     (env),
        .state   (state)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tready_reg <= 1'b0;
        end else begin
            tready_reg <= 1'b1;
        end
    end

    // Valid chain: S1 input, S2 gain, S3 envelope, S4 offset add, then the clamped output.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            valid_reg[0] <= 1'b0;
        end else begin
            valid_reg[0] <= accept;
        end
    end

    generate
        for (genvar gi = 1; gi < NUM_VALID; gi++) begin : g_valid
            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn) begin
                    valid_reg[gi] <= 1'b0;
                end else begin
                    valid_reg[gi] <= valid_reg[gi-1];
                end
            end
        end
    endgenerate

    // Truncating arithmetic shifts; amplitude and offset are picked up live at their stage.
    always_comb begin
        gain_prod = s1_data_reg * $signed({1'b0, cfg_amplitude});
        p1_next   = P_WIDTH'(gain_prod >>> 15);
        env_prod  = p1_reg * $signed({1'b0, s2_env_reg});
        p2_next   = P_WIDTH'(env_prod >>> 15);
        sum_next  = SUM_WIDTH'(p2_reg) + SUM_WIDTH'($signed(cfg_offset));
        sat_res   = saturate(sum_reg);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s1_data_reg <= '0;
            s1_env_reg  <= '0;
            p1_reg      <= '0;
            s2_env_reg  <= '0;
            p2_reg      <= '0;
            sum_reg     <= '0;
            code_reg    <= '0;
            sat_reg     <= 1'b0;
        end else begin
            if (accept) begin
                s1_data_reg <= $signed(s_axis_tdata);
                s1_env_reg  <= env;
            end
            if (valid_reg[0]) begin
                p1_reg     <= p1_next;
                s2_env_reg <= s1_env_reg;
            end
            if (valid_reg[1]) begin
                p2_reg <= p2_next;
            end
            if (valid_reg[2]) begin
                sum_reg <= sum_next;
            end
            if (valid_reg[3]) begin
                code_reg <= sat_res.code;
            end
            sat_reg <= valid_reg[3] & sat_res.clipped;
        end
    end

    assign s_axis_tready = tready_reg;
    assign m_axis_tvalid = valid_reg[NUM_VALID-1];
    assign m_axis_tdata  = {{(AXIS_TDATA_WIDTH-DAC_WIDTH){code_reg[DAC_WIDTH-1]}}, code_reg};
    assign saturated     = sat_reg;
    assign ramp_state    = state;

endmodule

// File: tb/tb_dac_output_stage.sv
// Randomised scoreboard bench for dac_output_stage against a sample-level
// reference model of the gain / envelope / offset / clamp chain.
module tb_dac_output_stage;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        s_axis_tvalid;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tready;
    logic [15:0] cfg_amplitude;
    logic [13:0] cfg_offset;
    logic [15:0] cfg_ramp_step;
    logic        enable;
    logic        m_axis_tvalid;
    logic [15:0] m_axis_tdata;
    logic [1:0]  ramp_state;
    logic        saturated;

    always #5 clk = ~clk;

    dac_output_stage dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tready (s_axis_tready),
        .cfg_amplitude (cfg_amplitude),
        .cfg_offset    (cfg_offset),
        .cfg_ramp_step (cfg_ramp_step),
        .enable        (enable),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .ramp_state    (ramp_state),
        .saturated     (saturated)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: envelope as a number moving toward 0 or 0x8000, outputs by plain arithmetic.
    typedef struct {
        int data;
        bit sat;
    } exp_t;

    exp_t     sbq[$];
    int       m_env;
    int       m_state;
    bit       m_ready;
    bit [4:0] acc_sh;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_env   = 0;
            m_state = 0;
            m_ready = 0;
            acc_sh  = '0;
            sbq.delete();
        end else begin
            bit     acc;
            longint p1;
            longint p2;
            longint s;
            int     step;
            exp_t   e;
            acc    = s_axis_tvalid && m_ready;
            acc_sh = {acc_sh[3:0], acc};
            if (acc) begin
                p1 = (longint'($signed(s_axis_tdata)) * longint'(cfg_amplitude)) >>> 15;
                p2 = (p1 * longint'(m_env)) >>> 15;
                s  = p2 + longint'($signed(cfg_offset));
                e.sat  = (s > 8191) || (s < -8192);
                e.data = (s > 8191) ? 8191 : (s < -8192) ? -8192 : int'(s);
                sbq.push_back(e);
                step = int'(cfg_ramp_step);
                if (enable) begin
                    m_env   = (step == 0 || m_env + step > 32768) ? 32768 : m_env + step;
                    m_state = (m_env == 32768) ? 2 : 1;
                end else begin
                    m_env   = (step == 0 || m_env - step < 0) ? 0 : m_env - step;
                    m_state = (m_env == 0) ? 0 : 3;
                end
            end
            m_ready = 1;
        end
    end

    always @(negedge clk) begin
        if (aresetn) begin
            exp_t e;
            check("tvalid", m_axis_tvalid, acc_sh[4]);
            check("tready", s_axis_tready, m_ready);
            check("ramp_state", ramp_state, m_state);
            if (m_axis_tvalid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got data %0d expected no output", $signed(m_axis_tdata));
                end else begin
                    e = sbq.pop_front();
                    check("data", $signed(m_axis_tdata), e.data);
                    check("saturated", saturated, e.sat);
                    $display("out data=%0d sat=%0d state=%0d", $signed(m_axis_tdata), saturated, ramp_state);
                end
            end
        end
    end

    task automatic drive(input bit v, input int d, input bit en);
        @(negedge clk);
        s_axis_tvalid = v;
        s_axis_tdata  = 16'(d);
        enable        = en;
    endtask

    task automatic drain();
        repeat (7) drive(1'b0, 0, enable);
    endtask

    initial begin
        bit en;
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        cfg_amplitude = 16'h8000;
        cfg_offset    = '0;
        cfg_ramp_step = '0;
        enable        = 1'b0;
        #1;
        check("rst_tready", s_axis_tready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_state", ramp_state, 0);
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        drive(1'b0, 0, 1'b0);
        drive(1'b0, 0, 1'b0);

        // Passthrough at unity gain
        for (int i = 0; i < 8; i++) drive(1'b1, (i % 2 == 0) ? 8191 : -8191, 1'b1);
        drain();

        // Saturation, negative then positive
        cfg_offset = 14'(-100);
        repeat (3) drive(1'b1, -8191, 1'b1);
        drain();
        cfg_offset    = '0;
        cfg_amplitude = 16'hFFFF;
        repeat (2) drive(1'b1, 8000, 1'b1);
        repeat (2) drive(1'b1, -8000, 1'b1);
        drain();

        // Back to IDLE, then ramp up by 0x2000 per sample
        cfg_amplitude = 16'h8000;
        drive(1'b1, 0, 1'b0);
        drain();
        cfg_ramp_step = 16'h2000;
        repeat (6) drive(1'b1, 8000, 1'b1);
        drain();

        // Ramp reversal from 0x4000 with a 300 LSB offset
        cfg_ramp_step = '0;
        drive(1'b1, 0, 1'b0);
        drain();
        cfg_offset    = 14'd300;
        cfg_ramp_step = 16'h2000;
        repeat (2) drive(1'b1, 8000, 1'b1);
        repeat (5) drive(1'b1, 8000, 1'b0);
        drain();

        // Bubbles; enable flips on non-valid cycles only and must be ignored there
        cfg_offset    = '0;
        cfg_ramp_step = 16'h1000;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) drive(1'b1, int'($urandom_range(0, 16000)) - 8000, i < 24);
            else            drive(1'b0, 0, !(i < 24));
        end
        drain();

        // Randomised blocks with fresh configuration between drained segments
        en = 1'b1;
        for (int b = 0; b < 8; b++) begin
            cfg_amplitude = 16'($urandom);
            cfg_offset    = 14'($urandom);
            cfg_ramp_step = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 16'h3000));
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 7) == 0) en = !en;
                drive($urandom_range(0, 3) != 0, int'($urandom), en);
            end
            drain();
        end

        // Asynchronous reset in the middle of a ramp
        cfg_amplitude = 16'h8000;
        cfg_offset    = '0;
        cfg_ramp_step = '0;
        drive(1'b1, 0, 1'b0);
        drain();
        cfg_ramp_step = 16'h1000;
        repeat (4) drive(1'b1, 5000, 1'b1);
        @(negedge clk);
        #2 aresetn = 1'b0;
        #1;
        check("arst_tvalid", m_axis_tvalid, 0);
        check("arst_tdata", m_axis_tdata, 0);
        check("arst_saturated", saturated, 0);
        check("arst_state", ramp_state, 0);
        check("arst_tready", s_axis_tready, 0);
        @(negedge clk);
        aresetn = 1'b1;
        drive(1'b0, 0, 1'b1);
        repeat (6) drive(1'b1, 5000, 1'b1);
        drain();

        check("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
